truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning cycles each input vector is held before sampling; legal range 1..255.
REQ-002 SHALL have parameter EXPECTED, default 8'h8D, meaning the 8-bit truth table the gate under test must produce.
REQ-003 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  sweep request, sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  synchronous sweep cancel.
REQ-007 SHALL have port gate_out  input  1  output of the 3-input gate under test, synchronous to clk.
REQ-008 SHALL have ports in1, in2, in3  output  1 each  stimulus to the gate, registered.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port table_out  output  8  captured truth table.
REQ-012 SHALL have port match  output  1  table_out equals EXPECTED, valid from done until next start.

Function
REQ-013 SHALL implement FSM with states IDLE, SETTLE, SAMPLE, DONE.
REQ-014 In IDLE, SHALL drive {in1,in2,in3}=3'b000 and, on start=1, clear table_out and match, set idx=0, cnt=0, go to SETTLE.
REQ-015 In SETTLE, SHALL drive {in1,in2,in3}=idx and increment cnt; when cnt==SETTLE_CYCLES-1 go to SAMPLE.
REQ-016 In SAMPLE, SHALL keep driving idx and write gate_out into table_out[7-idx] (vector 3'b000 maps to MSB).
REQ-017 From SAMPLE, if idx==7 go to DONE, else increment idx, clear cnt, go to SETTLE.
REQ-018 In DONE, SHALL assert done for exactly one cycle, compute match=(table_out==EXPECTED) including the final bit, and return to IDLE.
REQ-019 done SHALL be high in the cycle following 8*(SETTLE_CYCLES+1) rising edges after the edge that accepted start (40 with default).
REQ-020 start while busy SHALL be ignored; start asserted in the DONE cycle SHALL be ignored.
REQ-021 abort=1 in SETTLE or SAMPLE SHALL return to IDLE on the next edge, no done pulse, table_out holding partial bits, match=0; abort has priority over a same-cycle capture.
REQ-022 abort in IDLE or DONE SHALL have no effect.
REQ-023 table_out and match SHALL hold their values in IDLE until the next accepted start.
REQ-024 idx SHALL be 3 bits, cnt 8 bits; neither wraps within a sweep.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, in1..in3=0, busy=0, done=0, table_out=8'h00, match=0, idx=0, cnt=0.
REQ-026 Reset mid-sweep SHALL abandon the sweep without a done pulse; reset SHALL override start and abort.

Structure
REQ-027 Shared package truth_sweep_pkg SHALL hold the FSM state typedef, NUM_VECTORS=8, TT_WIDTH=8, and the default EXPECTED constant.
REQ-028 The per-vector hold counter SHALL be a sub-module settle_counter (load/clear, enable, terminal flag at SETTLE_CYCLES-1).

Verification
REQ-029 Gate model implementing 0x8D, SETTLE_CYCLES=4, start pulse -> vectors 000..111 each held 5 cycles, done at edge 40, table_out=8'h8D, match=1.
REQ-030 Gate model forced to constant 1 -> table_out=8'hFF, match=0, done still after 40 edges.
REQ-031 SETTLE_CYCLES=1, 0x8D model -> done after 16 edges, table_out=8'h8D.
REQ-032 abort during vector 3'b101 -> IDLE next cycle, no done, busy=0, inputs 000, match=0, table_out bits 7..3 as captured.
REQ-033 rst_n=0 at edge 20 of a sweep with start held high -> all outputs reset values, no done; after release, start pulse yields full sweep.
REQ-034 start pulses at edges 5 and 39 of a sweep, and in the DONE cycle -> ignored, exactly one done pulse, busy low one cycle after done.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Holds the FSM encoding, table geometry and the default golden table.
package truth_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    localparam int NUM_VECTORS = 8;
    localparam int TT_WIDTH = 8;
    localparam logic [TT_WIDTH-1:0] EXPECTED_DEFAULT = 8'h8D;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control, status and gate-stimulus bundle of the sweeper.
// master: requester plus gate under test; slave: the sweeper.
interface truth_table_sweeper_if;
    import truth_sweep_pkg::*;

    logic start;
    logic abort;
    logic gate_out;
    logic in1;
    logic in2;
    logic in3;
    logic busy;
    logic done;
    logic match;
    logic [TT_WIDTH-1:0] table_out;

    modport master (
        output start,
        output abort,
        output gate_out,
        input  in1,
        input  in2,
        input  in3,
        input  busy,
        input  done,
        input  match,
        input  table_out
    );

    modport slave (
        input  start,
        input  abort,
        input  gate_out,
        output in1,
        output in2,
        output in3,
        output busy,
        output done,
        output match,
        output table_out
    );

endinterface

// File: rtl/truth_table_sweeper_settle_counter.sv
// Per-vector hold counter with clear, enable and terminal flag.
// term rises once the vector has been held SETTLE_CYCLES cycles.
module settle_counter #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [7:0] TERM_VAL = 8'(SETTLE_CYCLES - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign term = (cnt == TERM_VAL);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 8 input vectors into a 3-input gate and captures its
// truth table, MSB = vector 3'b000, then compares against EXPECTED.
module truth_table_sweeper
    import truth_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [TT_WIDTH-1:0] EXPECTED = EXPECTED_DEFAULT
) (
    input logic clk,
    input logic rst_n,
    truth_table_sweeper_if.slave bus
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);

    state_e state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] stim_q, stim_d;
    logic [TT_WIDTH-1:0] tt_q, tt_d;
    logic match_q, match_d;
    logic cnt_clr, cnt_en, cnt_term;

    settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .term (cnt_term)
    );

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        tt_d = tt_q;
        match_d = match_q;
        cnt_clr = 1'b1;
        cnt_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tt_d = '0;
                    match_d = 1'b0;
                    idx_d = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    idx_d = '0;
                    match_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_en = !cnt_term;
                    if (cnt_term) begin
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                // abort wins: the bit for this vector is never written
                if (bus.abort) begin
                    idx_d = '0;
                    match_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    tt_d[3'd7 - idx_q] = bus.gate_out;
                    if (idx_q == LAST_IDX) begin
                        match_d = (tt_d == EXPECTED);
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        stim_d = (state_d == SETTLE || state_d == SAMPLE) ? idx_d : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q <= '0;
            stim_q <= '0;
            tt_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            stim_q <= stim_d;
            tt_q <= tt_d;
            match_q <= match_d;
        end
    end

    assign bus.in1 = stim_q[2];
    assign bus.in2 = stim_q[1];
    assign bus.in3 = stim_q[0];
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.table_out = tt_q;
    assign bus.match = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (hold 4 and hold 1) with table-driven
// gate models, a done scoreboard and hand-written abort/reset/start sequences.
module tb_truth_table_sweeper;

    localparam int S_A = 4;
    localparam int S_B = 1;
    localparam int NV = 6;

    typedef struct {
        int dsel;
        logic [7:0] gtt;
        logic [7:0] exp_tt;
        logic exp_m;
    } vec_t;

    typedef struct {
        logic [7:0] tt;
        logic m;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] gtt_a = 8'h8D;
    logic [7:0] gtt_b = 8'h8D;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int done_a = 0;
    int done_b = 0;
    bit pd_a = 1'b0;
    bit pd_b = 1'b0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    vec_t vecs[NV];

    truth_table_sweeper_if bus_a();
    truth_table_sweeper_if bus_b();

    truth_table_sweeper #(
        .SETTLE_CYCLES(S_A),
        .EXPECTED(8'h8D)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    truth_table_sweeper #(
        .SETTLE_CYCLES(S_B),
        .EXPECTED(8'h8D)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // registered gate models driven by a programmable truth table
    always @(posedge clk) begin
        if (!rst_n) begin
            bus_a.gate_out <= 1'b0;
            bus_b.gate_out <= 1'b0;
        end else begin
            bus_a.gate_out <= gtt_a[3'd7 - {bus_a.in1, bus_a.in2, bus_a.in3}];
            bus_b.gate_out <= gtt_b[3'd7 - {bus_b.in1, bus_b.in2, bus_b.in3}];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic chk_outs(input string name, input logic [2:0] stim,
                            input logic busy, input logic done,
                            input logic [7:0] tt, input logic m,
                            input logic [7:0] exp_tt, input logic exp_m);
        chk({name, "_in"}, 32'(stim), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_table"}, 32'(tt), 32'(exp_tt));
        chk({name, "_match"}, 32'(m), 32'(exp_m));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (pd_a) chk("busy_after_done_a", 32'(bus_a.busy), 32'd0);
        if (pd_b) chk("busy_after_done_b", 32'(bus_b.busy), 32'd0);
        if (bus_a.done) begin
            done_a++;
            chk("busy_in_done_a", 32'(bus_a.busy), 32'd1);
            if (sb_a.size() == 0) begin
                chk("unexpected_done_a", 32'd1, 32'd0);
            end else begin
                e = sb_a.pop_front();
                chk("table_a", 32'(bus_a.table_out), 32'(e.tt));
                chk("match_a", 32'(bus_a.match), 32'(e.m));
                chk("done_cycle_a", 32'(cyc), 32'(e.cyc));
            end
        end
        if (bus_b.done) begin
            done_b++;
            chk("busy_in_done_b", 32'(bus_b.busy), 32'd1);
            if (sb_b.size() == 0) begin
                chk("unexpected_done_b", 32'd1, 32'd0);
            end else begin
                e = sb_b.pop_front();
                chk("table_b", 32'(bus_b.table_out), 32'(e.tt));
                chk("match_b", 32'(bus_b.match), 32'(e.m));
                chk("done_cycle_b", 32'(cyc), 32'(e.cyc));
            end
        end
        pd_a = bus_a.done;
        pd_b = bus_b.done;
    end

    task automatic wait_done(input int dsel, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if ((dsel == 0 && bus_a.done) || (dsel == 1 && bus_b.done)) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        e.tt = v.exp_tt;
        e.m = v.exp_m;
        if (v.dsel == 0) begin
            gtt_a = v.gtt;
            e.cyc = cyc + 1 + 8 * (S_A + 1);
            sb_a.push_back(e);
            bus_a.start = 1'b1;
        end else begin
            gtt_b = v.gtt;
            e.cyc = cyc + 1 + 8 * (S_B + 1);
            sb_b.push_back(e);
            bus_b.start = 1'b1;
        end
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        wait_done(v.dsel, 8 * (S_A + 1) + 10);
        repeat (3) @(posedge clk);
        #1;
        if (v.dsel == 0) begin
            chk("hold_table_a", 32'(bus_a.table_out), 32'(v.exp_tt));
            chk("hold_match_a", 32'(bus_a.match), 32'(v.exp_m));
        end else begin
            chk("hold_table_b", 32'(bus_b.table_out), 32'(v.exp_tt));
            chk("hold_match_b", 32'(bus_b.match), 32'(v.exp_m));
        end
    endtask

    initial begin
        int base;
        bit hit;

        vecs[0] = '{0, 8'h8D, 8'h8D, 1'b1};
        vecs[1] = '{0, 8'hFF, 8'hFF, 1'b0};
        vecs[2] = '{1, 8'h8D, 8'h8D, 1'b1};
        vecs[3] = '{0, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{1, 8'h5A, 8'h5A, 1'b0};
        vecs[5] = '{1, 8'hFF, 8'hFF, 1'b0};

        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bus_b.start = 1'b0;
        bus_b.abort = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_outs("rst_a", {bus_a.in1, bus_a.in2, bus_a.in3}, bus_a.busy,
                 bus_a.done, bus_a.table_out, bus_a.match, 8'h00, 1'b0);
        chk_outs("rst_b", {bus_b.in1, bus_b.in2, bus_b.in3}, bus_b.busy,
                 bus_b.done, bus_b.table_out, bus_b.match, 8'h00, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i]);

        // abort in the SAMPLE cycle of vector 3'b101
        gtt_a = 8'h8D;
        base = done_a;
        bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        bus_a.start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if ({bus_a.in1, bus_a.in2, bus_a.in3} == 3'b101) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach_vec5", 32'(hit), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        bus_a.abort = 1'b1;
        @(posedge clk);
        #1;
        bus_a.abort = 1'b0;
        chk_outs("abort", {bus_a.in1, bus_a.in2, bus_a.in3}, bus_a.busy,
                 bus_a.done, bus_a.table_out, bus_a.match, 8'h88, 1'b0);
        bus_a.abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_a.abort = 1'b0;
        chk_outs("abort_idle", {bus_a.in1, bus_a.in2, bus_a.in3}, bus_a.busy,
                 bus_a.done, bus_a.table_out, bus_a.match, 8'h88, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_a - base), 32'd0);

        // reset at edge 20 of a sweep with start held high
        base = done_a;
        bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_outs("midrst", {bus_a.in1, bus_a.in2, bus_a.in3}, bus_a.busy,
                 bus_a.done, bus_a.table_out, bus_a.match, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_busy2", 32'(bus_a.busy), 32'd0);
        rst_n = 1'b1;
        bus_a.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_a - base), 32'd0);
        run_vec(vecs[0]);

        // start pulses at edges 5, 39 and in the DONE cycle are ignored
        base = done_a;
        gtt_a = 8'h8D;
        sb_a.push_back('{8'h8D, 1'b1, cyc + 1 + 8 * (S_A + 1)});
        bus_a.start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 44; k++) begin
            bus_a.start = (k == 5 || k == 39 || k == 41);
            @(posedge clk);
            #1;
        end
        bus_a.start = 1'b0;
        chk("ignore_one_done", 32'(done_a - base), 32'd1);
        chk("ignore_idle", 32'(bus_a.busy), 32'd0);
        repeat (50) @(posedge clk);
        #1;
        chk("ignore_no_more_done", 32'(done_a - base), 32'd1);
        chk("sb_a_empty", 32'(sb_a.size()), 32'd0);
        chk("sb_b_empty", 32'(sb_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
